// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
package booth_pkg;

    // Controller states: waiting for operands, iterating, holding a result
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Radix-4 Booth digit selected by each 3-bit multiplier window
    typedef enum logic [2:0] {
        REC_ZERO,
        REC_P1,
        REC_P2,
        REC_M1,
        REC_M2
    } recode_t;

    // Two multiplier bits retire per iteration; the extra iteration
    // consumes the two extension bits that make unsigned operands exact.
    function automatic int booth_n_iter(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational radix-4 Booth recoder: turns a 3-bit window of the
// multiplier into a partial product of 0, +/-M or +/-2M.
module booth_r4_recoder
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       window,
    input  logic [WIDTH+3:0] m,
    output logic [WIDTH+3:0] pp
);

    localparam int PW = WIDTH + 4;

    recode_t        rec;
    logic [PW-1:0]  m_dbl;

    assign m_dbl = {m[PW-2:0], 1'b0};

    // Decode the window {Q[1], Q[0], q_m1} into a Booth digit
    always_comb begin
        rec = REC_ZERO;
        case (window)
            3'b000, 3'b111: rec = REC_ZERO;
            3'b001, 3'b010: rec = REC_P1;
            3'b011:         rec = REC_P2;
            3'b100:         rec = REC_M2;
            default:        rec = REC_M1;
        endcase
    end

    // Form the partial product; negation is two's complement at full width
    always_comb begin
        pp = '0;
        case (rec)
            REC_P1:  pp = m;
            REC_P2:  pp = m_dbl;
            REC_M1:  pp = ~m + PW'(1);
            REC_M2:  pp = ~m_dbl + PW'(1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_multiplier.sv
// Sequential radix-4 Booth multiplier with valid/ready on both sides.
// Operands are extended to WIDTH+2 bits so the same signed datapath
// produces exact products for both signed and unsigned operations.
module booth_r4_seq_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    localparam int N_ITER = booth_n_iter(WIDTH);
    localparam int CNT_W  = $clog2(N_ITER + 1);
    localparam int AW     = WIDTH + 4;
    localparam int QW     = WIDTH + 2;

    state_t             state;
    state_t             next_state;

    logic [AW-1:0]      m_reg;
    logic [AW-1:0]      acc;
    logic [QW-1:0]      q_reg;
    logic               q_m1;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] result_reg;

    logic [QW-1:0]      ext_a;
    logic [QW-1:0]      ext_b;
    logic [AW-1:0]      pp;
    logic [AW-1:0]      sum;
    logic [AW-1:0]      next_acc;
    logic [QW-1:0]      next_q;
    logic               accept;
    logic               last_iter;

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign last_iter = (state == CALC) && (count == CNT_W'(1));
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = result_reg;

    assign ext_a = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                               : {2'b00, multiplicand};
    assign ext_b = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                               : {2'b00, multiplier};

    booth_r4_recoder #(
        .WIDTH (WIDTH)
    ) u_recoder (
        .window ({q_reg[1:0], q_m1}),
        .m      (m_reg),
        .pp     (pp)
    );

    // One iteration: add the partial product, then arithmetic shift of
    // {A, Q, q_m1} right by two, all as a single combinational step.
    always_comb begin
        sum      = acc + pp;
        next_acc = {{2{sum[AW-1]}}, sum[AW-1:2]};
        next_q   = {sum[1:0], q_reg[QW-1:2]};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; DONE can reissue straight into CALC with no bubble
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = accept ? CALC : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: latch extended operands on accept, iterate in CALC, and
    // capture the product on the final iteration so it stays stable in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg      <= '0;
            acc        <= '0;
            q_reg      <= '0;
            q_m1       <= 1'b0;
            count      <= '0;
            result_reg <= '0;
        end else if (accept) begin
            m_reg <= {{2{ext_a[QW-1]}}, ext_a};
            acc   <= '0;
            q_reg <= ext_b;
            q_m1  <= 1'b0;
            count <= CNT_W'(N_ITER);
        end else if (state == CALC) begin
            acc   <= next_acc;
            q_reg <= next_q;
            q_m1  <= q_reg[1];
            count <= count - CNT_W'(1);
            if (last_iter) begin
                result_reg <= {next_acc[WIDTH-3:0], next_q};
            end
        end
    end

endmodule
